// File: rtl/rgb_de_receiver.sv
// rgb_de_receiver: RGB565 HS/VS/DE sink with pixel coordinate
// recovery, timing measurement and lock detection.
module rgb_de_receiver #(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 11
) (
    input  logic             lcd_clk,
    input  logic             sys_rst_n,
    input  logic             in_hs,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic [15:0]      in_rgb,
    output logic             pix_valid,
    output logic [15:0]      pix_data,
    output logic [CNT_W-1:0] pix_xpos,
    output logic [CNT_W-1:0] pix_ypos,
    output logic             frame_start,
    output logic [CNT_W-1:0] meas_h_disp,
    output logic [CNT_W-1:0] meas_v_disp,
    output logic [CNT_W-1:0] meas_h_total,
    output logic             locked,
    output logic             fmt_err
);
    typedef enum logic [1:0] {
        ST_UNLOCK,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};
    localparam logic [3:0]       LF   = 4'(LOCK_FRAMES);

    logic             r_hs1, r_vs1, r_de1;
    logic [15:0]      r_rgb1;
    logic             r_hs2, r_vs2, r_act2, r_err2;
    logic [CNT_W-1:0] r_xcnt, r_ycnt, r_ref_w, r_hcnt;
    logic             r_ref_vld, r_mis, r_bad, r_open, r_hs_seen;
    state_t           r_state, w_state_nx;
    logic [3:0]       r_match, w_match_nx;
    logic             w_lock_err;

    logic             w_act, w_err;
    logic             w_act_rise, w_act_fall, w_vs_fall;
    logic             w_hs_fall, w_err_rise;
    logic [CNT_W-1:0] w_x, w_x_next, w_y_inc, w_lines, w_ref_eff;
    logic             w_x_sat, w_wcmp, w_mis_eff, w_bad_now;
    logic             w_good, w_same, w_eval;

    // Active pixels are DE samples inside VS-high; DE in VS-low is an error.
    assign w_act      = r_de1 & r_vs1;
    assign w_err      = r_de1 & ~r_vs1;
    assign w_act_rise = w_act & ~r_act2;
    assign w_act_fall = ~w_act & r_act2;
    assign w_vs_fall  = ~r_vs1 & r_vs2;
    assign w_hs_fall  = ~r_hs1 & r_hs2;
    assign w_err_rise = w_err & ~r_err2;

    assign w_x       = w_act_rise ? '0 : r_xcnt;
    assign w_x_sat   = (w_x == MAXV);
    assign w_x_next  = w_x_sat ? MAXV : w_x + 1'b1;
    assign w_y_inc   = (r_ycnt == MAXV) ? MAXV : r_ycnt + 1'b1;
    assign w_lines   = w_act_fall ? w_y_inc : r_ycnt;
    assign w_bad_now = w_err | (w_act & w_x_sat);

    // A line ending on the frame-start cycle still belongs to the old frame.
    assign w_wcmp    = w_act_fall & r_ref_vld & (r_xcnt != r_ref_w);
    assign w_mis_eff = r_mis | w_wcmp;
    assign w_ref_eff = r_ref_vld ? r_ref_w
                     : (w_act_fall ? r_xcnt : '0);

    assign w_good = (w_lines != '0) & ~w_mis_eff & ~r_bad;
    assign w_same = (w_ref_eff == meas_h_disp)
                  & (w_lines == meas_v_disp);
    assign w_eval = w_vs_fall & r_open;

    assign locked = (r_state == ST_LOCKED);

    // Stage 1: register the bus and keep a delayed copy for edge detection.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_de1  <= 1'b0;
            r_rgb1 <= '0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_act2 <= 1'b0;
            r_err2 <= 1'b0;
        end else begin
            r_hs1  <= in_hs;
            r_vs1  <= in_vs;
            r_de1  <= in_de;
            r_rgb1 <= in_rgb;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_act2 <= w_act;
            r_err2 <= w_err;
        end
    end

    // Per-frame counters, reference width and frame health flags.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xcnt    <= '0;
            r_ycnt    <= '0;
            r_ref_w   <= '0;
            r_ref_vld <= 1'b0;
            r_mis     <= 1'b0;
            r_bad     <= 1'b0;
            r_open    <= 1'b0;
        end else begin
            if (w_act) r_xcnt <= w_x_next;
            if (w_vs_fall) begin
                r_ycnt    <= '0;
                r_ref_vld <= 1'b0;
                r_mis     <= 1'b0;
                r_bad     <= w_bad_now;
                r_open    <= 1'b1;
            end else begin
                r_bad <= r_bad | w_bad_now;
                if (w_act_fall) begin
                    r_ycnt <= w_y_inc;
                    r_mis  <= w_mis_eff;
                    if (!r_ref_vld) begin
                        r_ref_w   <= r_xcnt;
                        r_ref_vld <= 1'b1;
                    end
                end
            end
        end
    end

    // Line period: cycles between HS falling edges, first edge only arms.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hcnt       <= '0;
            r_hs_seen    <= 1'b0;
            meas_h_total <= '0;
        end else if (w_hs_fall) begin
            r_hcnt    <= CNT_W'(1);
            r_hs_seen <= 1'b1;
            if (r_hs_seen) meas_h_total <= r_hcnt;
        end else if (r_hcnt != MAXV) begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Stage 2: pixel outputs, frame pulse, measurements and error strobe.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_xpos    <= '0;
            pix_ypos    <= '0;
            frame_start <= 1'b0;
            meas_h_disp <= '0;
            meas_v_disp <= '0;
            fmt_err     <= 1'b0;
        end else begin
            pix_valid   <= w_act;
            frame_start <= w_vs_fall;
            fmt_err     <= (r_open & (w_wcmp | w_err_rise))
                         | w_lock_err;
            if (w_act) begin
                pix_data <= r_rgb1;
                pix_xpos <= w_x;
                pix_ypos <= r_ycnt;
            end
            if (w_eval) begin
                meas_h_disp <= w_ref_eff;
                meas_v_disp <= w_lines;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_UNLOCK;
            r_match <= '0;
        end else begin
            r_state <= w_state_nx;
            r_match <= w_match_nx;
        end
    end

    // Lock next-state: evaluated once per completed frame.
    always_comb begin
        w_state_nx = r_state;
        w_match_nx = r_match;
        w_lock_err = 1'b0;
        if (w_eval) begin
            unique case (r_state)
                ST_UNLOCK: begin
                    if (w_good) begin
                        w_match_nx = 4'd1;
                        w_state_nx = (LF == 4'd1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_good && w_same) begin
                        w_match_nx = r_match + 4'd1;
                        if (r_match + 4'd1 >= LF) w_state_nx = ST_LOCKED;
                    end else begin
                        w_state_nx = ST_UNLOCK;
                        w_match_nx = '0;
                        w_lock_err = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!(w_good && w_same)) begin
                        w_state_nx = ST_UNLOCK;
                        w_match_nx = '0;
                        w_lock_err = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_UNLOCK;
                    w_match_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_de_receiver.sv
// tb_rgb_de_receiver: randomized frame stimulus checked cycle by cycle
// against a frame-level reference model, plus fixed milestone checks.
module tb_rgb_de_receiver;
    localparam int LF   = 2;
    localparam int CW   = 11;
    localparam int MAXV = (1 << CW) - 1;

    logic          lcd_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          in_hs     = 1'b1;
    logic          in_vs     = 1'b1;
    logic          in_de     = 1'b0;
    logic [15:0]   in_rgb    = '0;
    logic          pix_valid;
    logic [15:0]   pix_data;
    logic [CW-1:0] pix_xpos, pix_ypos;
    logic          frame_start;
    logic [CW-1:0] meas_h_disp, meas_v_disp, meas_h_total;
    logic          locked, fmt_err;

    rgb_de_receiver #(.LOCK_FRAMES(LF), .CNT_W(CW)) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_rgb(in_rgb),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
        .frame_start(frame_start),
        .meas_h_disp(meas_h_disp), .meas_v_disp(meas_v_disp),
        .meas_h_total(meas_h_total),
        .locked(locked), .fmt_err(fmt_err)
    );

    always #5 lcd_clk = ~lcd_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_fe  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state (frame-level view of the stream).
    bit     m_p_hs, m_p_vs, m_p_act, m_p_err;
    bit     m_open, m_hs_seen, m_mism, m_bad;
    int     m_run, m_lines, m_firstw, m_streak;
    longint m_last_hs, cyc;
    // Expected outputs after the sample most recently modelled.
    int     e_valid, e_data, e_x, e_y, e_fs;
    int     e_hd, e_vd, e_ht, e_lock, e_fe;

    function automatic int sat(input longint v);
        return (v > MAXV) ? MAXV : int'(v);
    endfunction

    task automatic model_reset();
        m_p_hs = 0; m_p_vs = 0; m_p_act = 0; m_p_err = 0;
        m_open = 0; m_hs_seen = 0; m_mism = 0; m_bad = 0;
        m_run = 0; m_lines = 0; m_firstw = -1; m_streak = 0;
        m_last_hs = 0;
        e_valid = 0; e_data = 0; e_x = 0; e_y = 0; e_fs = 0;
        e_hd = 0; e_vd = 0; e_ht = 0; e_lock = 0; e_fe = 0;
    endtask

    task automatic model_step(input bit hs, input bit vs, input bit de,
                              input logic [15:0] rgb);
        bit act, err, op, fe, good, same;
        int w, lf;
        act = de && vs;
        err = de && !vs;
        op  = m_open;
        fe  = 0;
        e_valid = 0;
        e_fs    = 0;
        if (!hs && m_p_hs) begin
            if (m_hs_seen) e_ht = sat(cyc - m_last_hs);
            m_hs_seen = 1;
            m_last_hs = cyc;
        end
        if (act) begin
            if (!m_p_act) m_run = 0;
            if (m_run >= MAXV) m_bad = 1;
            e_valid = 1;
            e_data  = int'(rgb);
            e_x     = sat(m_run);
            e_y     = sat(m_lines);
            m_run++;
        end
        if (!act && m_p_act) begin
            w = sat(m_run);
            if (m_firstw < 0) m_firstw = w;
            else if (w != m_firstw) begin
                m_mism = 1;
                if (op) fe = 1;
            end
            m_lines++;
        end
        if (!vs && m_p_vs) begin
            e_fs = 1;
            if (op) begin
                lf   = sat(m_lines);
                w    = (m_firstw < 0) ? 0 : m_firstw;
                good = (lf > 0) && !m_mism && !m_bad;
                same = (w == e_hd) && (lf == e_vd);
                if (!good || (m_streak > 0 && !same)) begin
                    if (m_streak > 0) fe = 1;
                    m_streak = 0;
                end else begin
                    m_streak++;
                end
                e_hd = w;
                e_vd = lf;
            end
            m_open = 1; m_lines = 0; m_firstw = -1;
            m_mism = 0; m_bad = 0;
        end
        if (err) begin
            m_bad = 1;
            if (!m_p_err && op) fe = 1;
        end
        e_lock  = (m_streak >= LF) ? 1 : 0;
        e_fe    = fe;
        m_p_hs  = hs;
        m_p_vs  = vs;
        m_p_act = act;
        m_p_err = err;
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "valid"},  32'(pix_valid),    32'(e_valid));
        check({pfx, "data"},   32'(pix_data),     32'(e_data));
        check({pfx, "xpos"},   32'(pix_xpos),     32'(e_x));
        check({pfx, "ypos"},   32'(pix_ypos),     32'(e_y));
        check({pfx, "fs"},     32'(frame_start),  32'(e_fs));
        check({pfx, "hdisp"},  32'(meas_h_disp),  32'(e_hd));
        check({pfx, "vdisp"},  32'(meas_v_disp),  32'(e_vd));
        check({pfx, "htot"},   32'(meas_h_total), 32'(e_ht));
        check({pfx, "locked"}, 32'(locked),       32'(e_lock));
        check({pfx, "fmterr"}, 32'(fmt_err),      32'(e_fe));
    endtask

    task automatic tick(input bit hs, input bit vs, input bit de,
                        input logic [15:0] rgb);
        in_hs = hs; in_vs = vs; in_de = de; in_rgb = rgb;
        @(posedge lcd_clk);
        #1;
        check_all("");
        if (fmt_err) n_fe++;
        if (sys_rst_n) model_step(hs, vs, de, rgb);
        else model_reset();
        cyc++;
    endtask

    task automatic gen_frame(
        input int ht, input int hsw, input int hbp, input int hact,
        input int vt, input int vsw, input int vbp, input int vact,
        input int short_ln, input int vsde, input bit inc,
        input int rst_ln, input int maxl,
        input int x_lock, input int x_hd, input int x_vd,
        input int x_ht, input int x_fe);
        int fe0, a, c0, rc, hold;
        bit hs, vs, de;
        logic [15:0] pat, rgb;
        fe0  = n_fe;
        pat  = 16'h0001;
        c0   = hsw + hbp;
        rc   = c0 + int'($urandom_range(10, hact - 50));
        hold = 0;
        for (int ln = 0; ln < vt && ln < maxl; ln++) begin
            for (int c = 0; c < ht; c++) begin
                a  = ln - vsw - vbp;
                hs = (c >= hsw);
                vs = (ln >= vsw);
                de = (a >= 0) && (a < vact) && (c >= c0)
                   && (c < c0 + ((a == short_ln) ? hact - 1 : hact));
                if (vsde > 0 && ln == 0 && c >= 100 && c < 100 + vsde)
                    de = 1;
                rgb = inc ? pat : 16'($urandom);
                pat = pat + 16'd1;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) sys_rst_n = 1'b1;
                end
                if (ln == rst_ln && c == rc) begin
                    check("pre_rst_locked", 32'(locked), 32'd1);
                    #2 sys_rst_n = 1'b0;
                    #1;
                    check("rst_valid",  32'(pix_valid),    32'd0);
                    check("rst_data",   32'(pix_data),     32'd0);
                    check("rst_xpos",   32'(pix_xpos),     32'd0);
                    check("rst_ypos",   32'(pix_ypos),     32'd0);
                    check("rst_locked", 32'(locked),       32'd0);
                    check("rst_hdisp",  32'(meas_h_disp),  32'd0);
                    check("rst_vdisp",  32'(meas_v_disp),  32'd0);
                    check("rst_htot",   32'(meas_h_total), 32'd0);
                    model_reset();
                    hold = 3;
                end
                tick(hs, vs, de, rgb);
                if (ln == 0 && c == 1) begin
                    check("fs_pulse",  32'(frame_start), 32'd1);
                    check("fs_locked", 32'(locked),      32'(x_lock));
                    check("fs_hdisp",  32'(meas_h_disp), 32'(x_hd));
                    check("fs_vdisp",  32'(meas_v_disp), 32'(x_vd));
                    check("fs_htot",   32'(meas_h_total), 32'(x_ht));
                end
                if (vsde > 0 && ln == 0 && c == 102)
                    check("vsde_drop", 32'(pix_valid), 32'd0);
                if (a == 0 && c == c0 + 1) begin
                    check("first_valid", 32'(pix_valid), 32'd1);
                    check("first_x", 32'(pix_xpos), 32'd0);
                    check("first_y", 32'(pix_ypos), 32'd0);
                end
                if (a == vact - 1 && c == c0 + hact && rst_ln < 0
                    && short_ln != vact - 1) begin
                    check("last_x", 32'(pix_xpos), 32'(hact - 1));
                    check("last_y", 32'(pix_ypos), 32'(vact - 1));
                end
            end
        end
        check("fe_count", 32'(n_fe - fe0), 32'(x_fe));
    endtask

    initial begin
        int sl;
        cyc = 0;
        model_reset();
        #1 sys_rst_n = 1'b0;
        #1;
        check("reset_valid",  32'(pix_valid),   32'd0);
        check("reset_fs",     32'(frame_start), 32'd0);
        check("reset_locked", 32'(locked),      32'd0);
        check("reset_fmterr", 32'(fmt_err),     32'd0);
        repeat (3) tick(1, 1, 0, 16'h0);
        sys_rst_n = 1'b1;
        repeat (10) tick(1, 1, 0, 16'h0);

        sl = int'($urandom_range(1, 2));
        // 480-wide source: h_total 525, HS 41, back porch 2.
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 0, 0, 0, 0);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 480, 4, 525, 0);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, sl, 0, 0, -1, 99,
                  1, 480, 4, 525, 1);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 480, 4, 525, 1);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 1, -1, 99,
                  0, 480, 4, 525, 0);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 5, 0, -1, 99,
                  1, 480, 4, 525, 1);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 480, 4, 525, 1);
        gen_frame(525, 41, 2, 480, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 480, 4, 525, 0);
        // 800-wide source: h_total 1056, HS 128, back porch 88.
        gen_frame(1056, 128, 88, 800, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  1, 480, 4, 525, 0);
        gen_frame(1056, 128, 88, 800, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 800, 4, 1056, 1);
        gen_frame(1056, 128, 88, 800, 7, 1, 1, 4, -1, 0, 0, -1, 99,
                  0, 800, 4, 1056, 0);
        gen_frame(1056, 128, 88, 800, 7, 1, 1, 4, -1, 0, 0, 3, 99,
                  1, 800, 4, 1056, 0);
        gen_frame(1056, 128, 88, 800, 7, 1, 1, 4, -1, 0, 0, -1, 3,
                  0, 0, 0, 1056, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rgb_de_receiver.md
Name: rgb_de_receiver

Overview:
- Sink end of the parallel RGB565 LCD interface: HS/VS/DE plus 16-bit data, all sampled on the pixel clock.
- Used as a loopback checker on the display path, and as a capture front-end for RGB sources feeding the recognition pipeline.
- Registers the bus, recovers pixel coordinates, and measures active width, active height and line period.
- Declares lock once the timing has stayed stable for a programmable number of frames.

Parameters:
- LOCK_FRAMES, 2: consecutive matching frame measurements required before locked asserts (1..15).
- CNT_W, 11: width of all coordinate and measurement counters; counters saturate at 2^CNT_W-1.

Ports:
- lcd_clk  in  1  pixel clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_hs  in  1  line sync; low during sync pulse, high otherwise.
- in_vs  in  1  frame sync; low during sync pulse, high otherwise.
- in_de  in  1  data enable; high for active pixels.
- in_rgb  in  16  RGB565 pixel, valid when in_de=1.
- pix_valid  out  1  pixel strobe.
- pix_data  out  16  captured pixel.
- pix_xpos  out  CNT_W  0-based column of pix_data.
- pix_ypos  out  CNT_W  0-based row of pix_data.
- frame_start  out  1  one-cycle pulse at the start of a new frame.
- meas_h_disp  out  CNT_W  active pixels per line, from the last complete frame.
- meas_v_disp  out  CNT_W  active lines, from the last complete frame.
- meas_h_total  out  CNT_W  lcd_clk cycles between consecutive HS falling edges.
- locked  out  1  timing stable.
- fmt_err  out  1  one-cycle pulse on any protocol or consistency violation.

Behaviour:
- Reset value: all outputs 0. Internal counters, the reference line width, the previous-frame measurements and the lock state are all cleared.
- Stage 1: in_hs, in_vs, in_de and in_rgb are registered. Edge detection compares stage 1 against a delayed copy.
- Stage 2 outputs are registered. Latency from in_de/in_rgb to pix_valid/pix_data is exactly 2 cycles.
- pix_valid is asserted for every DE-high sample while VS is high, regardless of lock. pix_data holds its last value when pix_valid=0.
- X counter: cleared on DE rising edge, +1 per DE-high sample. pix_xpos equals the counter value of that pixel.
- Y counter: +1 on each DE falling edge, cleared at frame start. pix_ypos equals the row index of the current line.
- Frame start is the VS falling edge. frame_start pulses at stage 2, aligned with the DE-low region.
- Line width: on each DE falling edge the completed x count is compared with the first line's width in this frame. Any difference sets a per-frame mismatch flag and pulses fmt_err.
- meas_h_total: HS-fall-to-HS-fall cycle count. It is latched at each HS falling edge, ignoring the first edge after reset.
- Frame-end update happens on the frame_start cycle, using the frame that just ended:
  - meas_h_disp is set to that frame's reference width.
  - meas_v_disp is set to that frame's line count.
  - The lock state machine evaluates.
- The first VS falling edge after reset only opens measurement: no update, no evaluation, no fmt_err.
- Lock state machine, evaluated at frame end:
  - UNLOCK: if the frame is good, go to CHECK with match_cnt=1. A good frame has lines>0, no mismatch flag, and no DE-in-VS error. If LOCK_FRAMES=1, go directly to LOCKED.
  - CHECK: a good frame with width and height equal to the previous frame increments match_cnt. On reaching LOCK_FRAMES, go to LOCKED. Otherwise return to UNLOCK with match_cnt=0 and pulse fmt_err.
  - LOCKED: an identical good frame stays LOCKED. Any difference or bad frame goes to UNLOCK and pulses fmt_err. locked falls on that same frame_start cycle.
- locked=1 exactly in the LOCKED state.
- DE high while VS low: the sample is dropped (pix_valid=0), fmt_err pulses once per offending run, and the frame is marked bad.
- Saturation: x, y and h_total counters stop at 2^CNT_W-1 and do not wrap. A saturated line marks the frame bad.
- Simultaneous DE falling edge and VS falling edge: the line is counted into the ending frame first, then frame_start processing runs.
- Reset mid-frame returns everything to reset values. The next VS falling edge is again treated as the first edge.

Test Plan:
1. 480x272 source with h_total=525, HS 41, back porch 2, v_total=286, VS 10, back porch 2, 3 frames:
   - First pixel appears 2 cycles after the first DE with xpos=0, ypos=0.
   - Last pixel of the frame has xpos=479, ypos=271.
   - meas_h_disp=480, meas_v_disp=272, meas_h_total=525.
   - locked=1 at the third frame_start (LOCK_FRAMES=2).
2. Locked stream, then one line with DE shortened to 479 → fmt_err pulses at that line's end; at the next frame_start locked=0. The following two clean frames relock.
3. DE asserted for 5 cycles during VS low → pix_valid stays 0 for those cycles, one fmt_err pulse, and the frame is counted bad.
4. Switch the source to 800x480 with h_total=1056 → the next frame_start reports meas_h_disp=800, meas_v_disp=480 with locked=0. locked=1 two frames later.
5. Assert sys_rst_n low mid-line while locked → all outputs are 0 immediately. The first subsequent VS falling edge gives a frame_start pulse but no measurement update.
6. in_rgb as an incrementing pattern starting at 16'h0001 → pix_data equals the pattern delayed by exactly 2 cycles, with no gaps inside a line.
